// File: rtl/led_pkg.sv
// Shared types, state encoding and default parameters for the LED strip sequencer.
package led_pkg;

  typedef logic [23:0] rgb_t;  // GRB, MSB first

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT,
    LATCH
  } seq_state_t;

  localparam int DEF_NUM_LED      = 10;
  localparam int DEF_LATCH_CYCLES = 6000;

  // (c * (b + 1)) >> 8 in 16 bits: b = 255 is an exact pass-through.
  function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

  function automatic rgb_t scale_rgb(input rgb_t c, input logic [7:0] b);
    return {scale_channel(c[23:16], b), scale_channel(c[15:8], b), scale_channel(c[7:0], b)};
  endfunction

endpackage

// File: rtl/pixel_buffer.sv
// Simple dual-port pixel store: one write port, one read port with a registered read.
module pixel_buffer
  import led_pkg::*;
#(
  parameter int DEPTH = DEF_NUM_LED,
  parameter int AW    = 4
) (
  input  logic          clk_in,
  input  logic          wr_en_in,
  input  logic [AW-1:0] wr_addr_in,
  input  logic [23:0]   wr_data_in,
  input  logic [AW-1:0] rd_addr_in,
  output logic [23:0]   rd_data_out
);

  rgb_t mem_q [DEPTH];
  rgb_t rd_data_q;

  // NOTE: the pixel store deliberately has no reset, so frame contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem_q[wr_addr_in] <= wr_data_in;
    end
    rd_data_q <= mem_q[rd_addr_in];
  end

  assign rd_data_out = rd_data_q;

endmodule

// File: rtl/led_strip_sequencer.sv
// Streams a buffered frame of pixels to a serial LED driver, then holds the latch gap.
// Optional: define SEQ_BRIGHTNESS_EN to scale every channel by brightness_in.
module led_strip_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LED      = DEF_NUM_LED,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_en_in,
  input  logic [7:0]  wr_addr_in,
  input  logic [23:0] wr_data_in,
  input  logic        start_in,
  input  logic [7:0]  brightness_in,
  input  logic        finished_in,
  output logic [23:0] rgb_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        frame_done_out
);

  localparam int AW = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam int CW = $clog2(LATCH_CYCLES) + 1;
  localparam logic [7:0]    LAST_IDX = 8'(NUM_LED - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LATCH_CYCLES - 1);

  seq_state_t    state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rgb_t          rgb_q, rgb_d;
  logic          valid_q, valid_d;
  logic          frame_done_q, frame_done_d;

  logic busy;
  logic wr_ok;
  rgb_t rd_data;
  rgb_t pix_scaled;

  assign busy = (state_q != IDLE);

  // The buffer is frozen for the whole frame; out-of-range writes never reach it.
  assign wr_ok = wr_en_in && !busy && ({1'b0, wr_addr_in} < 9'(NUM_LED));

  pixel_buffer #(
    .DEPTH (NUM_LED),
    .AW    (AW)
  ) u_pixel_buffer (
    .clk_in      (clk_in),
    .wr_en_in    (wr_ok),
    .wr_addr_in  (wr_addr_in[AW-1:0]),
    .wr_data_in  (wr_data_in),
    .rd_addr_in  (idx_q[AW-1:0]),
    .rd_data_out (rd_data)
  );

`ifdef SEQ_BRIGHTNESS_EN
  assign pix_scaled = scale_rgb(rd_data, brightness_in);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_in;
  assign pix_scaled        = rd_data;
`endif

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rgb_d        = rgb_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A start coinciding with the frame_done pulse belongs to the old frame.
        if (start_in && !frame_done_q) begin
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = SEND;
      SEND: begin
        rgb_d   = pix_scaled;
        valid_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (finished_in) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = LATCH;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = FETCH;
          end
        end
      end
      LATCH: begin
        if (cnt_q == LAST_CNT) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      rgb_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rgb_q        <= rgb_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rgb_out        = rgb_q;
  assign valid_out      = valid_q;
  assign busy_out       = busy;
  assign frame_done_out = frame_done_q;

endmodule

// File: doc/led_strip_sequencer.md
LED_STRIP_SEQUENCER -- requirements
Module: led_strip_sequencer

Interface
REQ-001 SHALL have parameter NUM_LED, default 10: number of pixels per frame (1..256).
REQ-002 SHALL have parameter LATCH_CYCLES, default 6000: low-gap length in clocks (60 us at 100 MHz).
REQ-003 SHALL have port clk_in  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1: synchronous, active-high reset.
REQ-005 SHALL have port wr_en_in  input  1: pixel-buffer write strobe.
REQ-006 SHALL have port wr_addr_in  input  8: pixel index to write.
REQ-007 SHALL have port wr_data_in  input  24: pixel colour, GRB order, MSB first.
REQ-008 SHALL have port start_in  input  1: request transmission of one full frame.
REQ-009 SHALL have port brightness_in  input  8: global scale factor.
REQ-010 SHALL have port finished_in  input  1: one-cycle pulse from the downstream led_driver when the current pixel is fully shifted out.
REQ-011 SHALL have port rgb_out  output  24: pixel to the driver's rgb_in.
REQ-012 SHALL have port valid_out  output  1: one-cycle pulse to the driver's valid_in.
REQ-013 SHALL have port busy_out  output  1: high while a frame is in progress.
REQ-014 SHALL have port frame_done_out  output  1: one-cycle pulse at the end of the latch gap.

Function
REQ-015 SHALL implement states IDLE, FETCH, SEND, WAIT, LATCH.
REQ-016 In IDLE, start_in=1 SHALL load pixel index 0, go to FETCH and raise busy_out on the next cycle.
REQ-017 FETCH SHALL present the pixel index to the buffer, which has 1-cycle read latency, then go to SEND.
REQ-018 SEND SHALL register rgb_out, pulse valid_out for exactly one cycle, then go to WAIT; valid_out is high exactly 2 cycles after start_in is sampled.
REQ-019 rgb_out SHALL stay stable from valid_out until finished_in is sampled in WAIT.
REQ-020 In WAIT, finished_in with index < NUM_LED-1 SHALL increment the index and go to FETCH; the next valid_out follows finished_in by 2 cycles.
REQ-021 In WAIT, finished_in with index = NUM_LED-1 SHALL go to LATCH and clear the latch counter.
REQ-022 LATCH SHALL count LATCH_CYCLES clocks with valid_out low, then pulse frame_done_out, drop busy_out and return to IDLE on the same edge.
REQ-023 start_in while busy_out=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 finished_in outside WAIT SHALL be ignored.
REQ-025 Writes SHALL be accepted only while busy_out=0; writes while busy are dropped; writes with wr_addr_in >= NUM_LED are dropped.
REQ-026 start_in and wr_en_in in the same IDLE cycle SHALL both be accepted, with the write landing before FETCH reads.
REQ-027 start_in=1 in the frame_done_out cycle SHALL be ignored; the next frame starts from IDLE on a later cycle.

Reset
REQ-028 rst_in SHALL force IDLE, index=0, latch counter=0, rgb_out=0, valid_out=0, busy_out=0 and frame_done_out=0 on the next edge, including mid-frame.
REQ-029 Reset SHALL NOT clear pixel-buffer contents.

Configuration
REQ-030 With SEQ_BRIGHTNESS_EN defined, each 8-bit channel SHALL become (c*(brightness_in+1))>>8, computed in 16 bits and registered in SEND with no extra latency; 255 passes colour unchanged and 0 maps to 0 only for c<256/1.
REQ-031 Without SEQ_BRIGHTNESS_EN, rgb_out SHALL be the raw buffer word and brightness_in SHALL be ignored; the port SHALL remain present.

Structure
REQ-032 Package led_pkg SHALL hold typedef rgb_t (24-bit GRB), the sequencer state enum, and default constants for NUM_LED and LATCH_CYCLES.
REQ-033 The buffer SHALL be sub-module pixel_buffer: simple dual-port, NUM_LED x 24, 1-cycle registered read.

Verification
REQ-034 Load pixels 0..9 = 0x00FF00+i, pulse start, model finished_in 30 cycles after each valid -> 10 valid pulses, rgb_out in index order, each valid 2 cycles after start or finished.
REQ-035 After the last finished_in -> exactly 6000 idle cycles, then frame_done_out for 1 cycle, busy_out falls and the state is IDLE.
REQ-036 start_in pulse during pixel 4, then write to address 2 while busy -> no restart, buffer[2] unchanged on the next frame.
REQ-037 rst_in during WAIT of pixel 5 -> all outputs 0 next cycle; a new start sends pixel 0 with the buffer retained.
REQ-038 With SEQ_BRIGHTNESS_EN, pixel 0xFF8040 and brightness 127 -> rgb_out 0x7F4020; brightness 255 -> 0xFF8040.
REQ-039 NUM_LED=1 and a spurious finished_in in IDLE -> ignored; one valid, then LATCH, then frame_done_out.
